// File: rtl/uart_tx_arbiter_pkg.sv
// uart_arb_pkg: shared types and sizing helper for the UART transmit arbiter
package uart_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;
  function automatic int stall_width(input int t);
    return t > 0 ? $clog2(t + 1) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: client byte streams, transmitter write port and arbiter status
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NREQ-1:0] src_valid;
  logic [NREQ*DATA_WIDTH-1:0] src_data;
  logic [NREQ-1:0] src_last;
  logic [NREQ-1:0] src_ready;
  logic tx_full;
  logic wr_uart;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NREQ-1:0] grant;
  logic busy;
  logic abort;
  modport master(
    output src_valid, src_data, src_last, tx_full,
    input src_ready, wr_uart, w_data, grant, busy, abort
  );
  modport slave(
    input src_valid, src_data, src_last, tx_full,
    output src_ready, wr_uart, w_data, grant, busy, abort
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_rr_pick: rotating-priority one-hot picker starting its search at ptr
module uart_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            any
);
  logic [PW-1:0] idx;
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter in front of a UART transmit FIFO,
// holding the grant until the owner's last byte and releasing it if the owner stalls.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int SW = stall_width(TIMEOUT);
  localparam logic [SW-1:0] LIM = TIMEOUT > 0 ? SW'(TIMEOUT - 1) : '0;
  arb_state_t state, state_n;
  logic [NREQ-1:0] grant, grant_n, pick_gnt;
  logic [PW-1:0] rr_ptr, rr_ptr_n, own, nxt;
  logic [SW-1:0] stall_cnt, stall_cnt_n;
  logic [DATA_WIDTH-1:0] w_data;
  logic abort, abort_n, pick_any, busy, own_valid, own_last, xfer;
  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req(bus.src_valid),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .any(pick_any)
  );
  always_comb begin
    own = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) begin
        own = PW'(i);
        w_data = bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  assign busy = state == ARB_XFER;
  assign own_valid = |(grant & bus.src_valid);
  assign own_last = |(grant & bus.src_last);
  assign xfer = busy & own_valid & ~bus.tx_full;
  assign nxt = own == PW'(NREQ - 1) ? '0 : own + 1'b1;
  // the counter reaches TIMEOUT on the edge that releases the grant
  always_comb begin
    state_n = state;
    grant_n = grant;
    rr_ptr_n = rr_ptr;
    stall_cnt_n = stall_cnt;
    abort_n = 1'b0;
    if (!busy) begin
      if (pick_any) begin
        state_n = ARB_XFER;
        grant_n = pick_gnt;
        stall_cnt_n = '0;
      end
    end else if (xfer) begin
      stall_cnt_n = '0;
      if (own_last) begin
        state_n = ARB_IDLE;
        grant_n = '0;
        rr_ptr_n = nxt;
      end
    end else if (!own_valid) begin
      if (TIMEOUT != 0 && stall_cnt >= LIM) begin
        abort_n = 1'b1;
        state_n = ARB_IDLE;
        grant_n = '0;
        rr_ptr_n = nxt;
        stall_cnt_n = '0;
      end else begin
        stall_cnt_n = stall_cnt != '1 ? stall_cnt + 1'b1 : stall_cnt;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
      grant <= '0;
      rr_ptr <= '0;
      stall_cnt <= '0;
      abort <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      rr_ptr <= rr_ptr_n;
      stall_cnt <= stall_cnt_n;
      abort <= abort_n;
    end
  end
  assign bus.src_ready = busy && !bus.tx_full ? grant : '0;
  assign bus.wr_uart = xfer;
  assign bus.w_data = w_data;
  assign bus.grant = grant;
  assign bus.busy = busy;
  assign bus.abort = abort;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares one UART transmit path between up to `NREQ` byte-stream clients. It sits directly in front of the transmitter's write interface (`wr_uart` / `w_data` / `tx_full`). It grants one client at a time and holds the grant until that client's last byte, so messages are never interleaved. A watchdog releases the grant if a client stalls mid-packet.

## Interface
Parameters:
- `NREQ`, 4: number of clients, 2..8.
- `DATA_WIDTH`, 8: byte width; must match the transmitter FIFO width.
- `TIMEOUT`, 255: client-stall cycles before forced release; 0 disables the watchdog.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high.
- `src_valid`  in  `NREQ`: client i has a byte on its slice of `src_data`.
- `src_data`  in  `NREQ*DATA_WIDTH`: client i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `src_last`  in  `NREQ`: the byte is the final byte of client i's packet.
- `src_ready`  out  `NREQ`: a byte is accepted from client i this cycle when `src_valid[i] & src_ready[i]`.
- `tx_full`  in  1: transmitter FIFO full.
- `wr_uart`  out  1: write strobe to the transmitter FIFO.
- `w_data`  out  `DATA_WIDTH`: byte to the transmitter FIFO.
- `grant`  out  `NREQ`: one-hot owner of the transmit path; 0 when idle.
- `busy`  out  1: a packet is in progress.
- `abort`  out  1: one-cycle pulse when the watchdog releases a grant.

## Operation
- State machine with two states:
  - IDLE:
    - If `src_valid` is nonzero, select the first i with `src_valid[i]=1`, searching `rr_ptr`, `rr_ptr+1`, … modulo `NREQ`.
    - Register the one-hot `grant`, clear `stall_cnt`, and move to XFER.
    - If `src_valid` is zero, stay in IDLE.
  - XFER, with owner g:
    - `src_ready[g] = ~tx_full`; all other `src_ready` bits are 0.
    - `wr_uart = src_valid[g] & ~tx_full`, and `w_data` is slice g of `src_data`.
    - On a transfer with `src_last[g]=1`: go to IDLE, set `rr_ptr = (g+1) mod NREQ`, and clear `grant`.
    - On a transfer with `src_last[g]=0`: clear `stall_cnt` and stay in XFER.
    - If `src_valid[g]=0`: increment `stall_cnt`.
    - While `tx_full=1` with `src_valid[g]=1`: hold `stall_cnt`. Back-pressure is never a timeout.
    - If `TIMEOUT≠0` and `stall_cnt` reaches `TIMEOUT`: pulse `abort`, go to IDLE, advance `rr_ptr` as above, and clear `grant`.
- In IDLE, `wr_uart=0`, `src_ready=0`, and `w_data` is don't-care. Requests are ignored until granted.
- `busy` = (state == XFER).
- `src_data`, `src_last`, and `src_valid` of non-owners are ignored.
- `stall_cnt` width is `$clog2(TIMEOUT+1)`, minimum 1, and it saturates.
- `rr_ptr` width is `$clog2(NREQ)`. It wraps from `NREQ-1` to 0.

## Timing
- Reset values: state IDLE, `rr_ptr=0`, `stall_cnt=0`, `grant=0`, `busy=0`, `abort=0`, `wr_uart=0`, `src_ready=0`.
- Arbitration latency: `src_valid` sampled high in IDLE at edge N gives `grant` and `busy` high after edge N. The earliest `wr_uart` is in the cycle following edge N.
- Throughput: one byte per cycle while `tx_full=0`.
- Packet gap: exactly one IDLE cycle between consecutive packets, including back-to-back packets from the same client.
- `wr_uart`, `w_data`, and `src_ready` are combinational from the registered state/`grant` plus `tx_full`/`src_valid`. There is no path from `src_valid` to `src_ready`.
- A single-byte packet (`src_last=1` on the first byte) returns to IDLE after that transfer.
- Reset mid-packet: all state clears immediately (asynchronous). A partial packet already in the FIFO is not retracted.
- Simultaneous timeout and transfer cannot occur, because a transfer clears the stall condition. The transfer takes priority.

## Structure
- Package `uart_arb_pkg`: state enum `{ARB_IDLE, ARB_XFER}`.
- One sub-module, `uart_rr_pick`: combinational rotating-priority picker.
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: one-hot `gnt[NREQ]`, `any`.
- The top level holds the FSM, the watchdog counter, and the output muxing.

## Test plan
- Single client, NREQ=4, client 2 sends 0x41, 0x42, 0x43 (last on 0x43) → `grant=0100`, three `wr_uart` pulses with matching `w_data`, then `grant=0`, `rr_ptr=3`.
- Clients 0 and 3 both request 2-byte packets from reset → client 0 is served first, then client 3 after one idle cycle. No bytes interleave in the `w_data` stream.
- `tx_full` held high for 5 cycles mid-packet → `wr_uart=0` and `src_ready=0` during the stall, no byte is lost or duplicated, and `abort` stays 0.
- With TIMEOUT=4, the owner drops `src_valid` after 1 byte → `abort` pulses after 4 stall cycles, `busy=0`, and a waiting client 1 is granted next.
- Rotation wrap: all four clients continuously send 1-byte packets → grant order 0, 1, 2, 3, 0, 1, with one-cycle gaps.
- `reset` asserted mid-packet → `grant`, `busy`, `wr_uart`, `src_ready` go to 0 immediately. After release, arbitration restarts from client 0.
